dmem_port_arbiter: RTL

Two-requester arbiter that shares the single-port, synchronous-read data RAM between the instruction-fetch path and the load/store unit. It accepts valid/ready requests from both sides and grants at most one RAM access per cycle. It drives the RAM port and returns read data, or a write acknowledge, to the owning requester exactly one cycle after the grant. It sits between the core's fetch/LSU stages and the data memory block.

---
 rtl/dmem_port_arbiter_pkg.sv | 17 +
 rtl/dmem_port_arbiter_if.sv | 52 +++++
 rtl/dmem_port_arbiter_rr_picker.sv | 38 +++
 rtl/dmem_port_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   req_id_e       : requester identity (fetch / load-store unit)
//   BE_FULL        : all-lanes byte enable used for fetch reads
//   WORD_LSB       : lowest byte-address bit that forms the RAM word address
//   MEM_AW_DEFAULT : default RAM word-address slice width
package dmem_port_arbiter_pkg;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LSU   = 1'b1
    } req_id_e;

    localparam logic [3:0]  BE_FULL        = 4'hF;
    localparam int unsigned WORD_LSB       = 2;
    localparam int unsigned MEM_AW_DEFAULT = 16;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of every request, response and RAM signal around the arbiter.
//   slave  : the arbiter's view (takes requests and mem_rdata, drives ready/rsp/mem_*)
//   master : the environment's view (fetch, LSU and the RAM together)
interface dmem_port_arbiter_if
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_AW        = MEM_AW_DEFAULT
) ();

    logic                     i_req_valid;
    logic                     i_req_ready;
    logic [ADDRESS_WIDTH-1:0] i_req_addr;
    logic                     i_rsp_valid;
    logic [DATA_WIDTH-1:0]    i_rsp_data;

    logic                     d_req_valid;
    logic                     d_req_ready;
    logic                     d_req_we;
    logic [3:0]               d_req_be;
    logic [ADDRESS_WIDTH-1:0] d_req_addr;
    logic [DATA_WIDTH-1:0]    d_req_wdata;
    logic                     d_rsp_valid;
    logic [DATA_WIDTH-1:0]    d_rsp_data;

    logic                     mem_en;
    logic                     mem_we;
    logic [3:0]               mem_be;
    logic [MEM_AW-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        input  mem_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        output mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_port_arbiter_rr_picker.sv
// Combinational two-way grant between fetch and LSU.
//   i_valid, d_valid : request valids
//   last_grant       : requester that won the previous grant
//   grant            : some requester wins this cycle
//   winner           : which one (meaningful only when grant = 1)
// Policy macro DMEM_ARB_RR_EN: defined -> round-robin on contention,
// undefined -> LSU always wins contention.
module dmem_rr_picker
    import dmem_port_arbiter_pkg::*;
(
    input  logic    i_valid,
    input  logic    d_valid,
    input  req_id_e last_grant,
    output logic    grant,
    output req_id_e winner
);

`ifndef DMEM_ARB_RR_EN
    // History is kept by the top but does not steer fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant  = i_valid | d_valid;
        winner = REQ_FETCH;
        if (i_valid && d_valid) begin
`ifdef DMEM_ARB_RR_EN
            winner = (last_grant == REQ_LSU) ? REQ_FETCH : REQ_LSU;
`else
            winner = REQ_LSU;
`endif
        end else if (d_valid) begin
            winner = REQ_LSU;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port synchronous-read data RAM between instruction fetch and
// the load/store unit. One access is granted per cycle with zero grant latency;
// the owner gets read data (or a store acknowledge with data 0) one cycle later.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; while low all ready/rsp_valid/mem_* are 0
//   bus   : dmem_port_arbiter_if.slave (fetch, LSU and RAM signals)
// Arbitration policy is selected by DMEM_ARB_RR_EN (see dmem_rr_picker).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_AW        = MEM_AW_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    dmem_port_arbiter_if.slave   bus
);

    logic    grant;
    req_id_e winner;

    req_id_e last_grant_q, last_grant_d;
    req_id_e rsp_owner_q, rsp_owner_d;
    logic    rsp_pending_q, rsp_pending_d;
    logic    rsp_is_store_q, rsp_is_store_d;

    logic                  i_req_ready, d_req_ready;
    logic                  i_rsp_valid, d_rsp_valid;
    logic [DATA_WIDTH-1:0] i_rsp_data, d_rsp_data;
    logic                  mem_en, mem_we;
    logic [3:0]            mem_be;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Byte offset and bits above the RAM window do not address the RAM.
    logic unused_addr;
    assign unused_addr = ^{bus.i_req_addr[WORD_LSB-1:0], bus.d_req_addr[WORD_LSB-1:0],
                           bus.i_req_addr[ADDRESS_WIDTH-1:MEM_AW+WORD_LSB],
                           bus.d_req_addr[ADDRESS_WIDTH-1:MEM_AW+WORD_LSB]};

    dmem_rr_picker u_picker (
        .i_valid    (bus.i_req_valid),
        .d_valid    (bus.d_req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .winner     (winner)
    );

    always_comb begin
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        i_rsp_data  = '0;
        d_rsp_data  = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (reset && grant) begin
            mem_en = 1'b1;
            if (winner == REQ_LSU) begin
                d_req_ready = 1'b1;
                mem_we      = bus.d_req_we;
                mem_be      = bus.d_req_be;
                mem_addr    = bus.d_req_addr[MEM_AW+WORD_LSB-1:WORD_LSB];
                mem_wdata   = bus.d_req_wdata;
            end else begin
                i_req_ready = 1'b1;
                mem_be      = BE_FULL;
                mem_addr    = bus.i_req_addr[MEM_AW+WORD_LSB-1:WORD_LSB];
            end
        end
        // Response of the previous grant; a reset in this cycle drops it.
        if (reset && rsp_pending_q) begin
            if (rsp_owner_q == REQ_FETCH) begin
                i_rsp_valid = 1'b1;
                i_rsp_data  = bus.mem_rdata;
            end else begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = rsp_is_store_q ? '0 : bus.mem_rdata;
            end
        end
    end

    always_comb begin
        last_grant_d   = last_grant_q;
        rsp_owner_d    = rsp_owner_q;
        rsp_is_store_d = rsp_is_store_q;
        rsp_pending_d  = grant;
        if (grant) begin
            last_grant_d   = winner;
            rsp_owner_d    = winner;
            rsp_is_store_d = (winner == REQ_LSU) && bus.d_req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q   <= REQ_LSU;  // fetch wins the first contention
            rsp_owner_q    <= REQ_FETCH;
            rsp_pending_q  <= 1'b0;
            rsp_is_store_q <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            rsp_owner_q    <= rsp_owner_d;
            rsp_pending_q  <= rsp_pending_d;
            rsp_is_store_q <= rsp_is_store_d;
        end
    end

    assign bus.i_req_ready = i_req_ready;
    assign bus.d_req_ready = d_req_ready;
    assign bus.i_rsp_valid = i_rsp_valid;
    assign bus.i_rsp_data  = i_rsp_data;
    assign bus.d_rsp_valid = d_rsp_valid;
    assign bus.d_rsp_data  = d_rsp_data;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_be      = mem_be;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;

endmodule
